// File: rtl/dense_layer_stream.sv
// Streaming fully-connected layer: N_OUT x N_IN signed fixed-point weights,
// one input element per cycle into N_OUT parallel MACs, results emitted
// serially with optional ReLU and saturation to DATA_W.
module dense_layer_stream #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN+1),
  localparam int RW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW    = (N_IN  > 1) ? $clog2(N_IN)  : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [RW-1:0]     w_row,
  input  logic [CW-1:0]     w_col,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_err,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  input  logic              x_last,
  output logic              x_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  output logic              y_last,
  input  logic              y_ready,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(N_OUT-1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_IN-1);

  state_t state, state_next;

  logic signed [DATA_W-1:0] w   [N_OUT][N_IN];
  logic signed [ACC_W-1:0]  acc [N_OUT];
  logic [CW-1:0]            x_idx;
  logic [RW-1:0]            y_idx;
  logic                     relu_q;

  logic x_hs, y_hs, elem_last, w_ok;

  // Full-precision signed product, sign-extended into the accumulator width
  function automatic logic signed [ACC_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  // Rescale, saturate to DATA_W, then apply the latched activation
  function automatic logic [DATA_W-1:0] post(input logic signed [ACC_W-1:0] a,
                                             input logic relu);
    logic signed [ACC_W-1:0]   s;
    logic [ACC_W-DATA_W:0]     hi;
    logic [DATA_W-1:0]         v;
    s  = a >>> FRAC_W;
    hi = s[ACC_W-1:DATA_W-1];
    if ((&hi) || !(|hi))
      v = s[DATA_W-1:0];
    else if (s[ACC_W-1])
      v = {1'b1, {(DATA_W-1){1'b0}}};
    else
      v = {1'b0, {(DATA_W-1){1'b1}}};
    if (relu && v[DATA_W-1])
      v = '0;
    return v;
  endfunction

  assign x_hs = x_valid & x_ready;
  assign y_hs = y_valid & y_ready;
  assign elem_last = (state == IDLE) ? (N_IN == 1) : (x_idx == LAST_COL);
  assign w_ok = (state == IDLE) && (w_row <= LAST_ROW) && (w_col <= LAST_COL);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (x_hs) state_next = (N_IN == 1) ? EMIT : ACCUM;
      ACCUM:   if (x_hs && x_idx == LAST_COL) state_next = EMIT;
      EMIT:    if (y_hs && y_idx == LAST_ROW) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and held datapath
  always_comb begin
    x_ready = (state != EMIT);
    y_valid = (state == EMIT);
    busy    = (state != IDLE);
    y_last  = (state == EMIT) && (y_idx == LAST_ROW);
    y_data  = '0;
    if (state == EMIT)
      y_data = post(acc[y_idx], relu_q);
  end

  // MAC array, element counters, activation latch and framing check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= '0;
      x_idx     <= '0;
      y_idx     <= '0;
      relu_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (x_hs && (x_last != elem_last))
        frame_err <= 1'b1;
      case (state)
        IDLE: if (x_hs) begin
          for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= mul(w[j][0], x_data);
          relu_q <= relu_en;
          x_idx  <= CW'(1);
          y_idx  <= '0;
        end
        ACCUM: if (x_hs) begin
          for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= acc[j] + mul(w[j][x_idx], x_data);
          x_idx <= (x_idx == LAST_COL) ? '0 : x_idx + CW'(1);
          y_idx <= '0;
        end
        EMIT: if (y_hs) begin
          y_idx <= (y_idx == LAST_ROW) ? '0 : y_idx + RW'(1);
          x_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Weight store; writes outside IDLE or out of range are dropped and flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < N_OUT; j++)
        for (int unsigned i = 0; i < N_IN; i++)
          w[j][i] <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_we && !w_ok;
      if (w_we && w_ok)
        w[w_row][w_col] <= w_data;
    end
  end

endmodule
